// File: rtl/date_pkg.sv
// Shared calendar constants and helpers for the date counter.
// Field select codes, month numbers, leap-year and month-length functions.
package date_pkg;

   localparam logic [2:0] SEL_DAY   = 3'b011;
   localparam logic [2:0] SEL_MONTH = 3'b100;
   localparam logic [2:0] SEL_YEAR  = 3'b101;

   localparam logic [3:0] JAN = 4'd1;
   localparam logic [3:0] FEB = 4'd2;
   localparam logic [3:0] MAR = 4'd3;
   localparam logic [3:0] APR = 4'd4;
   localparam logic [3:0] MAY = 4'd5;
   localparam logic [3:0] JUN = 4'd6;
   localparam logic [3:0] JUL = 4'd7;
   localparam logic [3:0] AUG = 4'd8;
   localparam logic [3:0] SEP = 4'd9;
   localparam logic [3:0] OCT = 4'd10;
   localparam logic [3:0] NOV = 4'd11;
   localparam logic [3:0] DEC = 4'd12;

   function automatic logic is_leap(input logic [31:0] y);
      return ((y % 32'd4 == 32'd0) && (y % 32'd100 != 32'd0)) || (y % 32'd400 == 32'd0);
   endfunction

   function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic leap);
      case (m)
         FEB:                return leap ? 5'd29 : 5'd28;
         APR, JUN, SEP, NOV: return 5'd30;
         default:            return 5'd31;
      endcase
   endfunction

endpackage

// File: rtl/date_counter_if.sv
// Control and date-output bundle between the time-keeping chain and the date counter.
interface date_counter_if #(parameter int YEAR_W = 12);

   logic              en_1;
   logic              carry_in;
   logic              up;
   logic              down;
   logic [2:0]        select_item;
   logic [4:0]        day;
   logic [3:0]        month;
   logic [YEAR_W-1:0] year_bin;
   logic [2:0]        weekday;
   logic              leap;
   logic              year_wrap;

   modport master (
      output en_1, carry_in, up, down, select_item,
      input  day, month, year_bin, weekday, leap, year_wrap
   );

   modport slave (
      input  en_1, carry_in, up, down, select_item,
      output day, month, year_bin, weekday, leap, year_wrap
   );

endinterface

// File: rtl/days_in_month_lut.sv
// Combinational month-length lookup.
module days_in_month_lut
   import date_pkg::*;
(
   input  logic [3:0] month,
   input  logic       leap,
   output logic [4:0] dim
);

   assign dim = days_in_month(month, leap);

endmodule

// File: rtl/date_counter.sv
// Calendar date counter: day/month/year/weekday with leap years, manual adjust
// with day clamping, and a one-cycle pulse when counting wraps the year range.
module date_counter
   import date_pkg::*;
#(
   parameter int         YEAR_W       = 12,
   parameter int         YEAR_MIN     = 2001,
   parameter int         YEAR_MAX     = 3000,
   parameter logic [2:0] SELECT_DAY   = SEL_DAY,
   parameter logic [2:0] SELECT_MONTH = SEL_MONTH,
   parameter logic [2:0] SELECT_YEAR  = SEL_YEAR,
   parameter logic [2:0] WEEKDAY_INIT = 3'd1
)(
   input  logic         clk_1Hz,
   input  logic         rst,
   date_counter_if.slave bus
);

   localparam logic [YEAR_W-1:0] Y_MIN = YEAR_W'(YEAR_MIN);
   localparam logic [YEAR_W-1:0] Y_MAX = YEAR_W'(YEAR_MAX);

   logic [4:0]        day_q, day_d, dim_cur, dim_pend;
   logic [3:0]        mon_q, mon_d;
   logic [YEAR_W-1:0] yr_q, yr_d;
   logic [2:0]        wd_q, wd_d, wd_inc, wd_dec;
   logic              wrap_q, wrap_d;
   logic              leap_cur, leap_pend;
   logic              sel_day, sel_mon, sel_yr, adj_mode, count;

   assign sel_day  = (bus.select_item == SELECT_DAY);
   assign sel_mon  = (bus.select_item == SELECT_MONTH);
   assign sel_yr   = (bus.select_item == SELECT_YEAR);
   assign adj_mode = sel_day | sel_mon | sel_yr;
   assign count    = !adj_mode && bus.en_1 && bus.carry_in;

   assign leap_cur  = is_leap(32'(yr_q));
   assign leap_pend = is_leap(32'(yr_d));
   assign wd_inc    = (wd_q == 3'd6) ? 3'd0 : wd_q + 3'd1;
   assign wd_dec    = (wd_q == 3'd0) ? 3'd6 : wd_q - 3'd1;

   // Second LUT sees the month/year about to be loaded so clamping lands in the same cycle.
   days_in_month_lut u_dim_cur  (.month(mon_q), .leap(leap_cur),  .dim(dim_cur));
   days_in_month_lut u_dim_pend (.month(mon_d), .leap(leap_pend), .dim(dim_pend));

   always_comb begin
      mon_d  = mon_q;
      yr_d   = yr_q;
      wrap_d = 1'b0;
      if (sel_mon) begin
         if (bus.up)        mon_d = (mon_q == DEC) ? JAN : mon_q + 4'd1;
         else if (bus.down) mon_d = (mon_q == JAN) ? DEC : mon_q - 4'd1;
      end else if (sel_yr) begin
         if (bus.up)        yr_d = (yr_q == Y_MAX) ? Y_MIN : yr_q + YEAR_W'(1);
         else if (bus.down) yr_d = (yr_q == Y_MIN) ? Y_MAX : yr_q - YEAR_W'(1);
      end else if (count && day_q >= dim_cur) begin
         if (mon_q == DEC) begin
            mon_d = JAN;
            if (yr_q == Y_MAX) begin
               yr_d   = Y_MIN;
               wrap_d = 1'b1;
            end else begin
               yr_d = yr_q + YEAR_W'(1);
            end
         end else begin
            mon_d = mon_q + 4'd1;
         end
      end
   end

   always_comb begin
      day_d = day_q;
      wd_d  = wd_q;
      if (sel_day) begin
         if (bus.up) begin
            day_d = (day_q >= dim_cur) ? 5'd1 : day_q + 5'd1;
            wd_d  = wd_inc;
         end else if (bus.down) begin
            day_d = (day_q <= 5'd1) ? dim_cur : day_q - 5'd1;
            wd_d  = wd_dec;
         end
      end else if ((sel_mon || sel_yr) && day_q > dim_pend) begin
         day_d = dim_pend;
      end else if (count) begin
         day_d = (day_q < dim_cur) ? day_q + 5'd1 : 5'd1;
         wd_d  = wd_inc;
      end
   end

   always_ff @(posedge clk_1Hz or posedge rst) begin
      if (rst) begin
         day_q  <= 5'd1;
         mon_q  <= JAN;
         yr_q   <= Y_MIN;
         wd_q   <= WEEKDAY_INIT;
         wrap_q <= 1'b0;
      end else begin
         day_q  <= day_d;
         mon_q  <= mon_d;
         yr_q   <= yr_d;
         wd_q   <= wd_d;
         wrap_q <= wrap_d;
      end
   end

   assign bus.day       = day_q;
   assign bus.month     = mon_q;
   assign bus.year_bin  = yr_q;
   assign bus.weekday   = wd_q;
   assign bus.leap      = leap_cur;
   assign bus.year_wrap = wrap_q;

endmodule

// File: tb/tb_date_counter.sv
// Directed self-checking bench for date_counter: reset, leap years, clamping,
// adjust priority, enable gating and the year-range wrap pulse.
module tb_date_counter;
   import date_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   date_counter_if #(.YEAR_W(12)) bus ();

   date_counter #(.YEAR_W(12)) dut (
      .clk_1Hz (clk),
      .rst     (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_date(input string tag, input int d, input int m, input int y, input int w);
      chk($sformatf("%s.day", tag),     32'(bus.day),      32'(d));
      chk($sformatf("%s.month", tag),   32'(bus.month),    32'(m));
      chk($sformatf("%s.year", tag),    32'(bus.year_bin), 32'(y));
      chk($sformatf("%s.weekday", tag), 32'(bus.weekday),  32'(w));
   endtask

   task automatic adj(input logic [2:0] sel, input bit dn, input int n);
      bus.select_item = sel;
      bus.up          = !dn;
      bus.down        = dn;
      repeat (n) tick();
      bus.up          = 1'b0;
      bus.down        = 1'b0;
      bus.select_item = 3'b000;
   endtask

   task automatic count_day();
      bus.en_1     = 1'b1;
      bus.carry_in = 1'b1;
      tick();
      bus.carry_in = 1'b0;
   endtask

   initial begin
      bus.en_1 = 1'b0; bus.carry_in = 1'b0; bus.up = 1'b0; bus.down = 1'b0;
      bus.select_item = 3'b000;
      #12 rst = 1'b0;
      #1;
      chk_date("reset", 1, 1, 2001, 1);
      chk("reset.wrap", 32'(bus.year_wrap), 0);
      chk("reset.leap", 32'(bus.leap), 0);

      tick();
      count_day();
      chk_date("count1", 2, 1, 2001, 2);

      // Enable low: carries must be ignored
      bus.en_1 = 1'b0; bus.carry_in = 1'b1;
      repeat (10) tick();
      bus.carry_in = 1'b0;
      chk_date("disable", 2, 1, 2001, 2);

      // Async reset between edges
      #3 rst = 1'b1;
      #1 chk_date("async_rst", 1, 1, 2001, 1);
      chk("async_rst.wrap", 32'(bus.year_wrap), 0);
      #1 rst = 1'b0;
      tick();

      // Adjust with carry pending: carry is dropped
      bus.en_1 = 1'b1; bus.carry_in = 1'b1;
      adj(SEL_MONTH, 0, 3);
      chk_date("mon_up3", 1, 4, 2001, 1);
      adj(SEL_DAY, 1, 1);
      chk_date("day_dn_wrap", 30, 4, 2001, 0);
      bus.carry_in = 1'b0;

      adj(SEL_MONTH, 1, 1);
      adj(SEL_DAY, 0, 1);
      chk_date("set_31_03", 31, 3, 2001, 1);
      adj(SEL_MONTH, 1, 1);
      chk_date("clamp_feb", 28, 2, 2001, 1);
      adj(SEL_YEAR, 0, 3);
      chk_date("yr_up3", 28, 2, 2004, 1);
      chk("leap2004", 32'(bus.leap), 1);

      // up beats down, carry ignored in adjust
      bus.select_item = SEL_YEAR; bus.up = 1'b1; bus.down = 1'b1;
      bus.en_1 = 1'b1; bus.carry_in = 1'b1;
      tick();
      bus.up = 1'b0; bus.down = 1'b0; bus.carry_in = 1'b0; bus.select_item = 3'b000;
      chk_date("prio_updown", 28, 2, 2005, 1);
      adj(SEL_YEAR, 1, 1);
      chk("yr_dn", 32'(bus.year_bin), 2004);

      count_day();
      chk_date("leap_29feb", 29, 2, 2004, 2);
      count_day();
      chk_date("leap_01mar", 1, 3, 2004, 3);

      adj(SEL_MONTH, 1, 1);
      adj(SEL_DAY, 1, 2);
      chk_date("set_28feb04", 28, 2, 2004, 1);
      adj(SEL_YEAR, 0, 96);
      chk("leap2100", 32'(bus.leap), 0);
      count_day();
      chk_date("y2100_01mar", 1, 3, 2100, 2);

      adj(SEL_MONTH, 1, 1);
      adj(SEL_DAY, 1, 1);
      adj(SEL_YEAR, 0, 300);
      chk("leap2400", 32'(bus.leap), 1);
      count_day();
      chk_date("y2400_29feb", 29, 2, 2400, 2);

      adj(SEL_MONTH, 1, 2);
      adj(SEL_DAY, 0, 2);
      adj(SEL_YEAR, 0, 600);
      adj(SEL_DAY, 0, 93);
      chk_date("set_31dec3000", 31, 12, 3000, 6);
      chk("pre_wrap", 32'(bus.year_wrap), 0);
      count_day();
      chk_date("wrap", 1, 1, 2001, 0);
      chk("wrap.pulse", 32'(bus.year_wrap), 1);
      tick();
      chk("wrap.pulse_end", 32'(bus.year_wrap), 0);
      chk_date("wrap.hold", 1, 1, 2001, 0);

      adj(SEL_YEAR, 1, 1);
      chk("yr_dn_wrap", 32'(bus.year_bin), 3000);
      chk("yr_dn_wrap.pulse", 32'(bus.year_wrap), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
